roi_crop_axis: RTL and testbench

- Parametrised successor of the fixed-size ROI cropper. Crops a rectangular region of interest from a raster-scan AXI-Stream video frame and forwards only ROI pixels downstream.
- Adds full tready backpressure, start-of-frame sync on tuser, per-frame latching of the coordinates, corner normalisation, selectable tlast mode and error reporting.
- Sits between the pixel source and downstream processing, on a single clock.

---
 rtl/roi_pkg.sv | 35 +++
 rtl/axis_reg_slice.sv | 46 ++++
 rtl/roi_crop_axis.sv | 226 ++++++++++++++++++++++
 tb/tb_roi_crop_axis.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/roi_pkg.sv
// -----------------------------------------------------------------------------
// roi_pkg
// Shared definitions for the ROI cropper:
//   - roi_state_e : frame-sync FSM states (WAIT_SOF, STREAM, SKIP)
//   - LAST_LINE / LAST_FRAME : values of the LAST_MODE parameter
//   - get_x / get_y : extract the x (upper half) and y (lower half) fields of a
//     32-bit corner word, keeping only the low cw bits of each field.
// -----------------------------------------------------------------------------
package roi_pkg;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        STREAM   = 2'd1,
        SKIP     = 2'd2
    } roi_state_e;

    localparam int LAST_LINE  = 0;
    localparam int LAST_FRAME = 1;

    // Mask with the low cw bits set (cw = 16 gives all ones).
    function automatic logic [15:0] field_mask(input int cw);
        logic [16:0] m;
        m = (17'h1 << cw) - 17'h1;
        return m[15:0];
    endfunction

    function automatic logic [15:0] get_x(input logic [31:0] xy, input int cw);
        return xy[31:16] & field_mask(cw);
    endfunction

    function automatic logic [15:0] get_y(input logic [31:0] xy, input int cw);
        return xy[15:0] & field_mask(cw);
    endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// -----------------------------------------------------------------------------
// axis_reg_slice
// Single-entry forward register slice for an AXI-Stream style handshake.
// The slice accepts a new word whenever it is empty or its current word is
// being taken in the same cycle, so full throughput is kept with one register.
// Ports:
//   clk_i, arst_ni        clock, asynchronous active-low reset
//   in_data/in_valid      upstream word and valid
//   in_ready              upstream ready (!out_valid | out_ready)
//   out_data/out_valid    registered downstream word and valid
//   out_ready             downstream ready
// -----------------------------------------------------------------------------
module axis_reg_slice #(
    parameter int W = 10
) (
    input  logic         clk_i,
    input  logic         arst_ni,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [W-1:0] data_r;
    logic         valid_r;

    assign in_ready  = !valid_r | out_ready;
    assign out_data  = data_r;
    assign out_valid = valid_r;

    // Load a new word whenever the slot is free or drains this cycle; hold otherwise.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            valid_r <= 1'b0;
            data_r  <= '0;
        end else if (in_ready) begin
            valid_r <= in_valid;
            if (in_valid) begin
                data_r <= in_data;
            end
        end
    end

endmodule

// File: rtl/roi_crop_axis.sv
// -----------------------------------------------------------------------------
// roi_crop_axis
// Crops a rectangular region of interest out of a raster-scan AXI-Stream frame.
// Corners are latched (and min/max normalised) on the start-of-frame beat;
// only in-window pixels are forwarded through a one-deep output register.
//
// Ports:
//   clk_i, arst_ni                 clock, asynchronous active-low reset
//   s_tdata_i/s_tvalid_i/s_tready_o input pixel stream
//   s_tuser_i                      start of frame (pixel (0,0))
//   s_tlast_i                      end of input line
//   xy_0_i, xy_1_i                 ROI corners: x at [16+COORD_W-1:16], y at [COORD_W-1:0]
//   m_tdata_o/m_tvalid_o/m_tready_i output ROI pixel stream
//   m_tuser_o                      first ROI pixel of the frame
//   m_tlast_o                      ROI line end (LAST_MODE=0) or ROI frame end (LAST_MODE=1)
//   roi_err_o                      one-cycle pulse: latched ROI lies outside the frame
//   err_o                          sticky: [0] line-length error, [1] early SOF
//   err_clr_i                      clears err_o (new errors in the same cycle win)
//
// Optional build macro ROI_CROP_STATS_EN adds:
//   frame_cnt_o   (16b) completed STREAM frames, wrapping
//   roi_pix_cnt_o (32b) ROI beats of the last completed frame
// -----------------------------------------------------------------------------
module roi_crop_axis
    import roi_pkg::*;
#(
    parameter int WIDTH     = 800,
    parameter int HEIGHT    = 600,
    parameter int DATA_W    = 8,
    parameter int COORD_W   = 11,
    parameter int LAST_MODE = 0
) (
    input  logic              clk_i,
    input  logic              arst_ni,
    input  logic [DATA_W-1:0] s_tdata_i,
    input  logic              s_tvalid_i,
    output logic              s_tready_o,
    input  logic              s_tuser_i,
    input  logic              s_tlast_i,
    input  logic [31:0]       xy_0_i,
    input  logic [31:0]       xy_1_i,
    output logic [DATA_W-1:0] m_tdata_o,
    output logic              m_tvalid_o,
    input  logic              m_tready_i,
    output logic              m_tuser_o,
    output logic              m_tlast_o,
    output logic              roi_err_o,
    output logic [1:0]        err_o,
    input  logic              err_clr_i
`ifdef ROI_CROP_STATS_EN
    ,
    output logic [15:0]       frame_cnt_o,
    output logic [31:0]       roi_pix_cnt_o
`endif
);

    localparam logic [15:0] X_LAST = 16'(WIDTH - 1);
    localparam logic [15:0] Y_LAST = 16'(HEIGHT - 1);

    roi_state_e  state_r;
    logic [15:0] x_r, y_r;
    logic [15:0] xmin_r, xmax_r, ymin_r, ymax_r;
    logic        roi_err_r;
    logic [1:0]  err_r;

    logic        beat_s, sof_s, synced_s;
    logic [15:0] cur_x_s, cur_y_s;
    logic [15:0] xmin_s, xmax_s, ymin_s, ymax_s;
    logic [15:0] ax_s, ay_s, bx_s, by_s;
    logic        roi_bad_s, stream_s, in_roi_s, emit_s;
    logic        line_end_s, frame_end_s, len_err_s, sof_err_s;
    logic        out_user_s, out_last_s;

    assign beat_s = s_tvalid_i & s_tready_o;

    // Decode the current beat: its raster position, the window that applies to it
    // (fresh corners on a SOF beat, latched ones otherwise) and the error conditions.
    always_comb begin
        sof_s    = beat_s & s_tuser_i;
        synced_s = sof_s | (state_r != WAIT_SOF);
        ax_s     = get_x(xy_0_i, COORD_W);
        ay_s     = get_y(xy_0_i, COORD_W);
        bx_s     = get_x(xy_1_i, COORD_W);
        by_s     = get_y(xy_1_i, COORD_W);
        if (sof_s) begin
            cur_x_s = 16'd0;
            cur_y_s = 16'd0;
            xmin_s  = (ax_s < bx_s) ? ax_s : bx_s;
            xmax_s  = (ax_s < bx_s) ? bx_s : ax_s;
            ymin_s  = (ay_s < by_s) ? ay_s : by_s;
            ymax_s  = (ay_s < by_s) ? by_s : ay_s;
        end else begin
            cur_x_s = x_r;
            cur_y_s = y_r;
            xmin_s  = xmin_r;
            xmax_s  = xmax_r;
            ymin_s  = ymin_r;
            ymax_s  = ymax_r;
        end
        roi_bad_s = ({1'b0, xmax_s} >= 17'(WIDTH)) | ({1'b0, ymax_s} >= 17'(HEIGHT));
        if (sof_s) begin
            stream_s = !roi_bad_s;
        end else begin
            stream_s = (state_r == STREAM);
        end
        in_roi_s    = (cur_x_s >= xmin_s) & (cur_x_s <= xmax_s) &
                      (cur_y_s >= ymin_s) & (cur_y_s <= ymax_s);
        emit_s      = beat_s & stream_s & in_roi_s;
        // An early tlast closes the line just like reaching the last column.
        line_end_s  = (cur_x_s == X_LAST) | s_tlast_i;
        frame_end_s = line_end_s & (cur_y_s == Y_LAST);
        len_err_s   = beat_s & synced_s & (s_tlast_i != (cur_x_s == X_LAST));
        sof_err_s   = sof_s & (state_r != WAIT_SOF) & ((x_r != 16'd0) | (y_r != 16'd0));
        out_user_s  = (cur_x_s == xmin_s) & (cur_y_s == ymin_s);
        if (LAST_MODE == LAST_FRAME) begin
            out_last_s = (cur_x_s == xmax_s) & (cur_y_s == ymax_s);
        end else begin
            out_last_s = (cur_x_s == xmax_s);
        end
    end

    // Frame-sync FSM with position counters, latched window and error flags.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_r   <= WAIT_SOF;
            x_r       <= 16'd0;
            y_r       <= 16'd0;
            xmin_r    <= 16'd0;
            xmax_r    <= 16'd0;
            ymin_r    <= 16'd0;
            ymax_r    <= 16'd0;
            roi_err_r <= 1'b0;
            err_r     <= 2'b00;
        end else begin
            roi_err_r <= sof_s & roi_bad_s;
            err_r     <= (err_clr_i ? 2'b00 : err_r) | {sof_err_s, len_err_s};
            if (sof_s) begin
                xmin_r <= xmin_s;
                xmax_r <= xmax_s;
                ymin_r <= ymin_s;
                ymax_r <= ymax_s;
            end
            // Beats before the first SOF carry no position and leave the counters alone.
            if (beat_s && synced_s) begin
                if (line_end_s) begin
                    x_r <= 16'd0;
                    y_r <= frame_end_s ? 16'd0 : (cur_y_s + 16'd1);
                end else begin
                    x_r <= cur_x_s + 16'd1;
                    y_r <= cur_y_s;
                end
            end
            if (beat_s) begin
                if (sof_s) begin
                    if (roi_bad_s) begin
                        state_r <= SKIP;
                    end else if (frame_end_s) begin
                        state_r <= WAIT_SOF;
                    end else begin
                        state_r <= STREAM;
                    end
                end else begin
                    case (state_r)
                        STREAM:   state_r <= frame_end_s ? WAIT_SOF : STREAM;
                        SKIP:     state_r <= SKIP;
                        WAIT_SOF: state_r <= WAIT_SOF;
                        default:  state_r <= WAIT_SOF;
                    endcase
                end
            end
        end
    end

    assign roi_err_o = roi_err_r;
    assign err_o     = err_r;

    axis_reg_slice #(
        .W (DATA_W + 2)
    ) u_slice (
        .clk_i     (clk_i),
        .arst_ni   (arst_ni),
        .in_data   ({out_user_s, out_last_s, s_tdata_i}),
        .in_valid  (emit_s),
        .in_ready  (s_tready_o),
        .out_data  ({m_tuser_o, m_tlast_o, m_tdata_o}),
        .out_valid (m_tvalid_o),
        .out_ready (m_tready_i)
    );

`ifdef ROI_CROP_STATS_EN
    logic [15:0] frame_cnt_r;
    logic [31:0] roi_pix_cnt_r;
    logic [31:0] run_cnt_r;
    logic [31:0] run_next_s;

    // Running ROI beat count of the frame in flight (a SOF restarts it).
    always_comb begin
        if (sof_s) begin
            run_next_s = {31'd0, emit_s};
        end else begin
            run_next_s = run_cnt_r + {31'd0, emit_s};
        end
    end

    // Publish frame statistics when a STREAM frame completes.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            frame_cnt_r   <= 16'd0;
            roi_pix_cnt_r <= 32'd0;
            run_cnt_r     <= 32'd0;
        end else if (beat_s) begin
            if (frame_end_s && stream_s) begin
                frame_cnt_r   <= frame_cnt_r + 16'd1;
                roi_pix_cnt_r <= run_next_s;
                run_cnt_r     <= 32'd0;
            end else begin
                run_cnt_r     <= run_next_s;
            end
        end
    end

    assign frame_cnt_o   = frame_cnt_r;
    assign roi_pix_cnt_o = roi_pix_cnt_r;
`endif

endmodule

// File: tb/tb_roi_crop_axis.sv
// -----------------------------------------------------------------------------
// tb_roi_crop_axis
// Self-checking bench for roi_crop_axis on an 8x6 frame (pixel = y*8+x + tag*64).
// Two instances share the stimulus: dut0 with LAST_MODE=0, dut1 with LAST_MODE=1.
// Expected output beats come from a pixel-level window model driven by the
// positions the bench itself sends.
// -----------------------------------------------------------------------------
module tb_roi_crop_axis;

    localparam int W = 8;
    localparam int H = 6;

    logic        clk, rst_n;
    logic [7:0]  s_tdata;
    logic        s_tvalid, s_tuser, s_tlast;
    logic [31:0] xy0, xy1;
    logic        m_tready, err_clr;
    logic        s_tready0, s_tready1;
    logic [7:0]  m_tdata0, m_tdata1;
    logic        m_tvalid0, m_tvalid1, m_tuser0, m_tuser1, m_tlast0, m_tlast1;
    logic        roi_err0, roi_err1;
    logic [1:0]  err0, err1;
`ifdef ROI_CROP_STATS_EN
    logic [15:0] fc0, fc1;
    logic [31:0] rp0, rp1;
`endif

    roi_crop_axis #(.WIDTH(W), .HEIGHT(H), .DATA_W(8), .COORD_W(11), .LAST_MODE(0)) dut0 (
        .clk_i(clk), .arst_ni(rst_n), .s_tdata_i(s_tdata), .s_tvalid_i(s_tvalid),
        .s_tready_o(s_tready0), .s_tuser_i(s_tuser), .s_tlast_i(s_tlast),
        .xy_0_i(xy0), .xy_1_i(xy1), .m_tdata_o(m_tdata0), .m_tvalid_o(m_tvalid0),
        .m_tready_i(m_tready), .m_tuser_o(m_tuser0), .m_tlast_o(m_tlast0),
        .roi_err_o(roi_err0), .err_o(err0), .err_clr_i(err_clr)
`ifdef ROI_CROP_STATS_EN
        , .frame_cnt_o(fc0), .roi_pix_cnt_o(rp0)
`endif
    );

    roi_crop_axis #(.WIDTH(W), .HEIGHT(H), .DATA_W(8), .COORD_W(11), .LAST_MODE(1)) dut1 (
        .clk_i(clk), .arst_ni(rst_n), .s_tdata_i(s_tdata), .s_tvalid_i(s_tvalid),
        .s_tready_o(s_tready1), .s_tuser_i(s_tuser), .s_tlast_i(s_tlast),
        .xy_0_i(xy0), .xy_1_i(xy1), .m_tdata_o(m_tdata1), .m_tvalid_o(m_tvalid1),
        .m_tready_i(m_tready), .m_tuser_o(m_tuser1), .m_tlast_o(m_tlast1),
        .roi_err_o(roi_err1), .err_o(err1), .err_clr_i(err_clr)
`ifdef ROI_CROP_STATS_EN
        , .frame_cnt_o(fc1), .roi_pix_cnt_o(rp1)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    int rdy_mode = 0;   // 0: always ready, 1: toggle, 2: random, 3: never ready
    bit gaps = 0;

    logic [9:0] exp0[$], exp1[$], got0[$], got1[$];
    int rerr0 = 0, rerr1 = 0, exp_rerr = 0;

    // window model state
    int ax, ay, bx, by;
    int mxmin, mxmax, mymin, mymax;
    bit mvalid = 0;

    typedef struct {
        int ax, ay, bx, by, rdy, nb, nerr;
        logic [9:0] first, last;
    } vec_t;
    vec_t tbl[9];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pix(input int tag, input int x, input int y);
        return 8'(y * 8 + x + tag * 64);
    endfunction

    task automatic set_roi(input int a_x, input int a_y, input int b_x, input int b_y);
        ax = a_x; ay = a_y; bx = b_x; by = b_y;
        xy0 = {5'd0, 11'(a_x), 5'd0, 11'(a_y)};
        xy1 = {5'd0, 11'(b_x), 5'd0, 11'(b_y)};
    endtask

    // Window model: what each sent pixel should produce downstream.
    task automatic model_beat(input int tag, input int x, input int y, input bit u);
        bit ou, l0, l1;
        if (u) begin
            mxmin = (ax < bx) ? ax : bx;  mxmax = (ax < bx) ? bx : ax;
            mymin = (ay < by) ? ay : by;  mymax = (ay < by) ? by : ay;
            mvalid = (mxmax < W) && (mymax < H);
            if (!mvalid) exp_rerr++;
        end
        if (mvalid && x >= mxmin && x <= mxmax && y >= mymin && y <= mymax) begin
            ou = (x == mxmin) && (y == mymin);
            l0 = (x == mxmax);
            l1 = (x == mxmax) && (y == mymax);
            exp0.push_back({ou, l0, pix(tag, x, y)});
            exp1.push_back({ou, l1, pix(tag, x, y)});
        end
        if (x == W - 1 && y == H - 1) mvalid = 0;
    endtask

    task automatic send_px(input int tag, input int x, input int y, input bit u, input bit l);
        bit acc;
        int w;
        model_beat(tag, x, y, u);
        if (gaps) repeat ($urandom_range(0, 2)) tick();
        s_tdata = pix(tag, x, y); s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
        acc = 0; w = 0;
        while (!acc && w < 200) begin
            @(negedge clk);
            acc = s_tready0;
            @(posedge clk);
            #1;
            w++;
        end
        if (!acc) begin
            n_checks++; n_errors++;
            $display("FAIL accept_timeout: beat (%0d,%0d) not accepted, expected acceptance", x, y);
        end
        s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
    endtask

    task automatic send_frame(input int tag);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                send_px(tag, x, y, (x == 0 && y == 0), (x == W - 1));
    endtask

    task automatic compare_q(input string nm);
        int w = 0;
        while ((got0.size() < exp0.size() || got1.size() < exp1.size()) && w < 400) begin
            tick();
            w++;
        end
        repeat (4) tick();
        chk({nm, "_cnt0"}, got0.size(), exp0.size());
        chk({nm, "_cnt1"}, got1.size(), exp1.size());
        for (int i = 0; i < exp0.size() && i < got0.size(); i++)
            chk($sformatf("%s_beat0_%0d", nm, i), 32'(got0[i]), 32'(exp0[i]));
        for (int i = 0; i < exp1.size() && i < got1.size(); i++)
            chk($sformatf("%s_beat1_%0d", nm, i), 32'(got1[i]), 32'(exp1[i]));
        chk({nm, "_roierr0"}, rerr0, exp_rerr);
        chk({nm, "_roierr1"}, rerr1, exp_rerr);
    endtask

    task automatic clear_q();
        exp0.delete(); exp1.delete(); got0.delete(); got1.delete();
        rerr0 = 0; rerr1 = 0; exp_rerr = 0;
    endtask

    task automatic check_idle(input string nm);
        chk({nm, "_mvalid"}, {m_tvalid0, m_tvalid1}, 2'b00);
        chk({nm, "_mdata"}, {m_tdata0, m_tdata1}, 16'h0000);
        chk({nm, "_muser_mlast"}, {m_tuser0, m_tuser1, m_tlast0, m_tlast1}, 4'h0);
        chk({nm, "_err"}, {roi_err0, roi_err1, err0, err1}, 6'h00);
    endtask

    // Downstream ready pattern.
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: m_tready = 1'b1;
                1: m_tready = ~m_tready;
                2: m_tready = 1'($urandom_range(0, 1));
                default: m_tready = 1'b0;
            endcase
        end
    end

    // Output monitor: collects transfers, checks stall stability and ready.
    initial begin
        bit hold_v = 0;
        logic [9:0] hold_w = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_v = 0;
            end else begin
                if (hold_v)
                    chk("hold_stable", {m_tvalid0, m_tuser0, m_tlast0, m_tdata0}, {1'b1, hold_w});
                if (m_tvalid0 && !m_tready) begin
                    chk("sready_full", s_tready0, 1'b0);
                    hold_v = 1;
                    hold_w = {m_tuser0, m_tlast0, m_tdata0};
                end else begin
                    hold_v = 0;
                end
                if (m_tvalid0 && m_tready) got0.push_back({m_tuser0, m_tlast0, m_tdata0});
                if (m_tvalid1 && m_tready) got1.push_back({m_tuser1, m_tlast1, m_tdata1});
                if (roi_err0) rerr0++;
                if (roi_err1) rerr1++;
            end
        end
    end

    initial begin
        tbl[0] = '{2, 1, 4, 2, 0, 6, 0, 10'h20A, 10'h114};  // basic crop
        tbl[1] = '{4, 2, 2, 1, 0, 6, 0, 10'h20A, 10'h114};  // swapped corners
        tbl[2] = '{2, 1, 4, 2, 1, 6, 0, 10'h20A, 10'h114};  // toggling ready
        tbl[3] = '{2, 1, 8, 2, 0, 0, 1, 10'h000, 10'h000};  // x out of bounds
        tbl[4] = '{2, 1, 4, 2, 2, 6, 0, 10'h20A, 10'h114};  // recovers after bad ROI
        tbl[5] = '{0, 0, 7, 5, 0, 48, 0, 10'h200, 10'h12F}; // full frame
        tbl[6] = '{7, 5, 7, 5, 0, 1, 0, 10'h32F, 10'h32F};  // single corner pixel
        tbl[7] = '{3, 6, 0, 0, 0, 0, 1, 10'h000, 10'h000};  // y out of bounds
        tbl[8] = '{5, 0, 5, 5, 1, 6, 0, 10'h305, 10'h12D};  // one column

        rst_n = 1'b0; s_tdata = '0; s_tvalid = 0; s_tuser = 0; s_tlast = 0;
        err_clr = 0; set_roi(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Table-driven frames
        for (int i = 0; i < 9; i++) begin
            rdy_mode = tbl[i].rdy;
            set_roi(tbl[i].ax, tbl[i].ay, tbl[i].bx, tbl[i].by);
            send_frame(0);
            compare_q($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_nbeats", i), got0.size(), tbl[i].nb);
            chk($sformatf("vec%0d_roierr", i), rerr0, tbl[i].nerr);
            if (tbl[i].nb > 0 && got0.size() > 0 && got1.size() > 0) begin
                chk($sformatf("vec%0d_first", i), 32'(got0[0]), 32'(tbl[i].first));
                chk($sformatf("vec%0d_last0", i), 32'(got0[got0.size()-1]), 32'(tbl[i].last));
                chk($sformatf("vec%0d_last1", i), 32'(got1[got1.size()-1]), 32'(tbl[i].last));
            end
            clear_q();
        end
        chk("table_err", {err0, err1}, 4'h0);

        // Early SOF at input beat 20
        rdy_mode = 2; gaps = 1;
        set_roi(2, 1, 4, 2);
        for (int i = 0; i < 20; i++) send_px(1, i % W, i / W, (i == 0), (i % W == W - 1));
        set_roi(1, 3, 6, 4);
        send_frame(2);
        compare_q("esof");
        chk("esof_err", {err0, err1}, 4'b1010);
        clear_q();

        // Early tlast with err_clr held on the same beat, then a missing tlast
        set_roi(3, 0, 6, 1);
        for (int x = 0; x < 6; x++) begin
            err_clr = (x == 5);
            send_px(3, x, 0, (x == 0), (x == 5));
        end
        err_clr = 0;
        for (int y = 1; y < H; y++)
            for (int x = 0; x < W; x++)
                send_px(3, x, y, 1'b0, (x == W - 1) && !(y == 3));
        compare_q("etlast");
        chk("etlast_err", {err0, err1}, 4'b0101);
        clear_q();
        err_clr = 1; tick(); err_clr = 0; tick();
        chk("errclr", {err0, err1}, 4'b0000);

        // Reset while a ROI beat sits in the output register
        rdy_mode = 3; gaps = 0;
        set_roi(2, 1, 4, 2);
        for (int i = 0; i < 11; i++) send_px(0, i % W, i / W, (i == 0), (i % W == W - 1));
        @(negedge clk);
        chk("prerst_held", {m_tvalid0, m_tdata0}, {1'b1, 8'd10});
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check_idle("midrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_q(); mvalid = 0; rdy_mode = 0;
        for (int i = 11; i < 24; i++) send_px(0, i % W, i / W, 1'b0, (i % W == W - 1));
        set_roi(1, 1, 2, 2);
        send_frame(1);
        compare_q("postrst");
        chk("postrst_err", {err0, err1}, 4'h0);
        clear_q();

        // Randomised frames
        rdy_mode = 2; gaps = 1;
        for (int f = 0; f < 12; f++) begin
            set_roi($urandom_range(0, 8), $urandom_range(0, 6), $urandom_range(0, 8), $urandom_range(0, 6));
            send_frame($urandom_range(0, 3));
            compare_q($sformatf("rnd%0d", f));
            clear_q();
        end
        chk("rnd_err", {err0, err1}, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
